alu_16: RTL and testbench

Registered 16-bit arithmetic/logic unit for the MIPS-style datapath. Each clock it takes two 16-bit operands, a carry/borrow input and a 4-bit MIPS ALU-control opcode. It registers the result together with carry, signed-overflow and signed-compare flags. It sits between the register-file read ports and the writeback/branch logic.

---
 rtl/alu_16.sv | 106 ++++++++++
 tb/tb_alu_16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_16.sv
// Registered 16-bit MIPS-style ALU: result plus carry, overflow and signed-compare
// flags are captured on every rising clock edge with one cycle of latency.
module alu_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        Cin,
    input  logic [3:0]  opcode,
    output logic [15:0] out,
    output logic        Cout,
    output logic        lt,
    output logic        eq,
    output logic        gt,
    output logic        V
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [16:0] add_sum;
    logic [16:0] sub_sum;
    logic [3:0]  shamt;
    logic        slt_s;
    logic        slt_u;

    logic [15:0] out_d,  out_q;
    logic        cout_d, cout_q;
    logic        v_d,    v_q;
    logic        lt_d,   lt_q;
    logic        eq_d,   eq_q;
    logic        gt_d,   gt_q;

    // Subtraction reuses the adder form x + ~y + ~Cin so Cout reads as "no borrow".
    assign add_sum = {1'b0, x} + {1'b0, y}  + {16'b0, Cin};
    assign sub_sum = {1'b0, x} + {1'b0, ~y} + {16'b0, ~Cin};
    assign shamt   = y[3:0];
    assign slt_s   = $signed(x) < $signed(y);
    assign slt_u   = x < y;

    always_comb begin
        out_d  = 16'h0000;
        cout_d = 1'b0;
        v_d    = 1'b0;
        lt_d   = slt_s;
        eq_d   = (x == y);
        gt_d   = $signed(x) > $signed(y);
        case (opcode)
            OP_AND:  out_d = x & y;
            OP_OR:   out_d = x | y;
            OP_ADD: begin
                out_d  = add_sum[15:0];
                cout_d = add_sum[16];
                v_d    = (x[15] == y[15]) && (add_sum[15] != x[15]);
            end
            OP_XOR:  out_d = x ^ y;
            OP_SUB: begin
                out_d  = sub_sum[15:0];
                cout_d = sub_sum[16];
                v_d    = (x[15] != y[15]) && (sub_sum[15] != x[15]);
            end
            OP_SLT:  out_d = {15'b0, slt_s};
            OP_SLL:  out_d = x << shamt;
            OP_SRL:  out_d = x >> shamt;
            OP_SRA:  out_d = 16'($signed(x) >>> shamt);
            OP_SLTU: out_d = {15'b0, slt_u};
            OP_NOR:  out_d = ~(x | y);
            default: out_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 16'h0000;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
            v_q    <= v_d;
            lt_q   <= lt_d;
            eq_q   <= eq_d;
            gt_q   <= gt_d;
        end
    end

    assign out  = out_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed cases, async reset behaviour and
// randomized operations compared against an arithmetic reference model.
module tb_alu_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x, y, out;
    logic        Cin, Cout, lt, eq, gt, V;
    logic [3:0]  opcode;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        lt;
        logic        eq;
        logic        gt;
    } exp_t;

    alu_16 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .out    (out),
        .Cin    (Cin),
        .Cout   (Cout),
        .lt     (lt),
        .eq     (eq),
        .gt     (gt),
        .V      (V),
        .opcode (opcode)
    );

    always #5 clk = ~clk;

    // Reference model works on plain integers: true sums, range checks for overflow.
    function automatic exp_t model(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic ci);
        exp_t e;
        int   ua, ub, sa, sb, s, n;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        n  = int'(b[3:0]);
        e  = '0;
        s  = 0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                s    = ua + ub + int'(ci);
                e.r  = s[15:0];
                e.c  = (s > 65535);
                s    = sa + sb + int'(ci);
                e.v  = (s > 32767) || (s < -32768);
            end
            4'b0011: e.r = a ^ b;
            4'b0110: begin
                s    = ua - ub - int'(ci);
                e.r  = s[15:0];
                e.c  = (ua >= ub + int'(ci));
                s    = sa - sb - int'(ci);
                e.v  = (s > 32767) || (s < -32768);
            end
            4'b0111: e.r = (sa < sb) ? 16'h0001 : 16'h0000;
            4'b1000: begin s = ua << n;  e.r = s[15:0]; end
            4'b1001: begin s = ua >> n;  e.r = s[15:0]; end
            4'b1010: begin s = sa >>> n; e.r = s[15:0]; end
            4'b1011: e.r = (ua < ub) ? 16'h0001 : 16'h0000;
            4'b1100: e.r = ~(a | b);
            default: e.r = 16'h0000;
        endcase
        e.lt = (sa < sb);
        e.eq = (ua == ub);
        e.gt = (sa > sb);
        return e;
    endfunction

    task automatic check_output(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag, exp_t e);
        check_output({tag, ".out"},  out,          e.r);
        check_output({tag, ".Cout"}, {15'b0, Cout}, {15'b0, e.c});
        check_output({tag, ".V"},    {15'b0, V},    {15'b0, e.v});
        check_output({tag, ".lt"},   {15'b0, lt},   {15'b0, e.lt});
        check_output({tag, ".eq"},   {15'b0, eq},   {15'b0, e.eq});
        check_output({tag, ".gt"},   {15'b0, gt},   {15'b0, e.gt});
    endtask

    task automatic apply_stimulus(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic ci);
        @(negedge clk);
        opcode = op;
        x      = a;
        y      = b;
        Cin    = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(string tag, logic [3:0] op, logic [15:0] a, logic [15:0] b, logic ci);
        apply_stimulus(op, a, b, ci);
        check_all(tag, model(op, a, b, ci));
    endtask

    logic [15:0] edge_vals [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    initial begin
        logic [15:0] ra, rb, held;
        logic [3:0]  rop;
        logic        rci;

        rst_n  = 1'b0;
        x      = 16'h0;
        y      = 16'h0;
        Cin    = 1'b0;
        opcode = 4'h0;
        #12;
        check_all("reset", exp_t'('0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add5", 4'b0010, 16'h0005, 16'h0005, 1'b0);
        check_output("add5.spec", out, 16'h000A);
        check_output("add5.flags", {10'b0, Cout, V, lt, eq, gt, 1'b0}, 16'b0000_0000_0000_0100);
        run_op("sub3_8", 4'b0110, 16'h0003, 16'h0008, 1'b0);
        check_output("sub3_8.spec", {out[15:0]}, 16'hFFFB);
        check_output("sub3_8.cout", {15'b0, Cout}, 16'h0000);
        run_op("sub8_3", 4'b0110, 16'h0008, 16'h0003, 1'b0);
        check_output("sub8_3.spec", out, 16'h0005);
        check_output("sub8_3.cout", {15'b0, Cout}, 16'h0001);
        run_op("and", 4'b0000, 16'h000B, 16'h0009, 1'b0);
        check_output("and.spec", out, 16'h0009);
        run_op("add_ovf", 4'b0010, 16'h7FFF, 16'h0001, 1'b0);
        check_output("add_ovf.spec", {out[15:1], V}, {15'h4000, 1'b1});
        run_op("add_carry", 4'b0010, 16'hFFFF, 16'h0001, 1'b0);
        check_output("add_carry.cout", {15'b0, Cout}, 16'h0001);
        run_op("add_cin", 4'b0010, 16'h0001, 16'h0001, 1'b1);
        check_output("add_cin.spec", out, 16'h0003);
        run_op("sub_bin", 4'b0110, 16'h0005, 16'h0005, 1'b1);
        run_op("sra", 4'b1010, 16'h8000, 16'h0004, 1'b0);
        check_output("sra.spec", out, 16'hF800);
        run_op("srl", 4'b1001, 16'h8000, 16'h0004, 1'b0);
        check_output("srl.spec", out, 16'h0800);
        run_op("sll_hi", 4'b1000, 16'h0003, 16'hFFF2, 1'b0);
        check_output("sll_hi.spec", out, 16'h000C);
        run_op("slt", 4'b0111, 16'hFFFF, 16'h0001, 1'b0);
        check_output("slt.spec", out, 16'h0001);
        run_op("sltu", 4'b1011, 16'hFFFF, 16'h0001, 1'b0);
        check_output("sltu.spec", out, 16'h0000);
        run_op("nor", 4'b1100, 16'h00F0, 16'h000F, 1'b0);
        check_output("nor.spec", out, 16'hFF00);
        run_op("undef", 4'b1111, 16'h1234, 16'h4321, 1'b1);
        check_output("undef.spec", out, 16'h0000);
        run_op("or", 4'b0001, 16'hA0A0, 16'h0505, 1'b1);
        run_op("xor", 4'b0011, 16'hFFFF, 16'h0F0F, 1'b1);

        // Mid-cycle input changes must not reach the registered outputs.
        run_op("hold", 4'b0010, 16'h1000, 16'h0234, 1'b0);
        held = out;
        #2;
        x = 16'hDEAD;
        opcode = 4'b0011;
        #1;
        check_output("hold.stable", out, held);

        // Async reset between edges, then first edge after release.
        run_op("rst_pre", 4'b0010, 16'h1234, 16'h1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst_async", exp_t'('0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_release.out", out, 16'h2345);

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rci = 1'($urandom);
            if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op($sformatf("rand%0d", i), rop, ra, rb, rci);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
